// File: rtl/if_fetch.sv
// IF-stage fetch unit.
// Owns the PC and keeps at most one instruction-bus transaction in flight.
// It presents the fetched instruction to the IF/ID register and raises
// stallreq_o whenever no instruction is available. It also absorbs branch
// redirects (delay slot), exception flushes and downstream stalls.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        stallreq_o,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // no request outstanding
        BUSY    = 2'd1,  // request outstanding
        HOLD    = 2'd2,  // instruction buffered while downstream stalls
        DISCARD = 2'd3   // flushed request still outstanding
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buffer;
    logic        pending;
    logic [31:0] pending_target;

    logic        present;
    logic        advance;
    logic [31:0] next_pc;

    // Only bit 1 of the stall vector concerns the IF stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5:2], stall[0]};

    // Hand-off decode and the presented instruction / stall request.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        present    = 1'b0;
        advance    = 1'b0;
        next_pc    = pc + 32'd4;
        if_pc      = pc;
        if_inst    = 32'h0;
        stallreq_o = 1'b0;

        present = ((state == BUSY) && ibus_ack_i) || (state == HOLD);
        advance = present && !stall[1] && !flush;

        if (branch_flag_i)
            next_pc = branch_target_address_i;
        else if (pending)
            next_pc = pending_target;

        unique case (state)
            IDLE:    stallreq_o = 1'b1;
            DISCARD: stallreq_o = 1'b1;
            BUSY: begin
                if (ibus_ack_i)
                    if_inst = ibus_rdata_i;
                else
                    stallreq_o = 1'b1;
            end
            HOLD:    if_inst = buffer;
            default: stallreq_o = 1'b1;
        endcase
    end

    // Fetch state machine: PC, bus request/address, buffer and pending branch.
    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            ibus_req_o     <= 1'b0;
            ibus_addr_o    <= 32'h0;
            pending        <= 1'b0;
            pending_target <= 32'h0;
            buffer         <= 32'h0;
        end else begin
            // A branch from ID that cannot be taken this cycle is remembered
            // until the delay-slot instruction hands off. Flush wins.
            if (flush || advance) begin
                pending <= 1'b0;
            end else if (branch_flag_i) begin
                pending        <= 1'b1;
                pending_target <= branch_target_address_i;
            end

            unique case (state)
                IDLE: begin
                    if (flush) begin
                        pc <= new_pc;
                    end else begin
                        ibus_req_o  <= 1'b1;
                        ibus_addr_o <= pc;
                        state       <= BUSY;
                    end
                end

                BUSY: begin
                    if (flush && ibus_ack_i) begin
                        pc         <= new_pc;
                        ibus_req_o <= 1'b0;
                        state      <= IDLE;
                    end else if (flush) begin
                        // The bus cannot be cancelled; drain the old request.
                        pc    <= new_pc;
                        state <= DISCARD;
                    end else if (ibus_ack_i && stall[1]) begin
                        buffer     <= ibus_rdata_i;
                        ibus_req_o <= 1'b0;
                        state      <= HOLD;
                    end else if (advance) begin
                        // Back-to-back fetch: the request stays asserted.
                        pc          <= next_pc;
                        ibus_addr_o <= next_pc;
                    end
                end

                HOLD: begin
                    if (flush) begin
                        pc    <= new_pc;
                        state <= IDLE;
                    end else if (advance) begin
                        pc          <= next_pc;
                        ibus_req_o  <= 1'b1;
                        ibus_addr_o <= next_pc;
                        state       <= BUSY;
                    end
                end

                DISCARD: begin
                    if (flush)
                        pc <= new_pc;
                    if (ibus_ack_i) begin
                        ibus_req_o <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch.
// Inputs are driven just after the falling edge. Outputs are checked 1 ns
// later, well before the next rising edge.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic        stallreq_o;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus_req_o              (ibus_req_o),
        .ibus_addr_o             (ibus_addr_o),
        .ibus_ack_i              (ibus_ack_i),
        .ibus_rdata_i            (ibus_rdata_i),
        .stallreq_o              (stallreq_o),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs just after the falling edge. Leave time to settle.
    task automatic drive(input logic ack, input logic [31:0] rdata, input logic [5:0] stl,
                         input logic fl, input logic [31:0] npc,
                         input logic br, input logic [31:0] tgt);
        @(negedge clk);
        ibus_ack_i              = ack;
        ibus_rdata_i            = rdata;
        stall                   = stl;
        flush                   = fl;
        new_pc                  = npc;
        branch_flag_i           = br;
        branch_target_address_i = tgt;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state: IDLE with no request outstanding.
        check("rst_req",      {31'b0, ibus_req_o}, 32'h0);
        check("rst_addr",     ibus_addr_o,         32'h0);
        check("rst_stallreq", {31'b0, stallreq_o}, 32'h1);
        check("rst_pc",       if_pc,               32'h0);
        check("rst_inst",     if_inst,             32'h0);

        // Zero-wait fetch of 0x0.
        drive(1'b1, 32'h100, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("zw_req",      {31'b0, ibus_req_o}, 32'h1);
        check("zw_addr",     ibus_addr_o,         32'h0);
        check("zw_pc",       if_pc,               32'h0);
        check("zw_inst",     if_inst,             32'h100);
        check("zw_stallreq", {31'b0, stallreq_o}, 32'h0);

        // Wait states on 0x4: two waiting cycles, then ack.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            check("ws_stallreq", {31'b0, stallreq_o}, 32'h1);
            check("ws_addr",     ibus_addr_o,         32'h4);
            check("ws_inst",     if_inst,             32'h0);
        end
        drive(1'b1, 32'h104, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("ws_ack_stallreq", {31'b0, stallreq_o}, 32'h0);
        check("ws_ack_addr",     ibus_addr_o,         32'h4);
        check("ws_ack_pc",       if_pc,               32'h4);
        check("ws_ack_inst",     if_inst,             32'h104);

        // Downstream stall on the ack for 0x8.
        drive(1'b1, 32'h108, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        check("st_ack_pc",   if_pc,   32'h8);
        check("st_ack_inst", if_inst, 32'h108);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
            check("hold_req",      {31'b0, ibus_req_o}, 32'h0);
            check("hold_inst",     if_inst,             32'h108);
            check("hold_pc",       if_pc,               32'h8);
            check("hold_stallreq", {31'b0, stallreq_o}, 32'h0);
        end
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("hold_rel_inst", if_inst, 32'h108);
        drive(1'b1, 32'h10C, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("after_hold_req",  {31'b0, ibus_req_o}, 32'h1);
        check("after_hold_addr", ibus_addr_o,         32'hC);
        check("after_hold_inst", if_inst,             32'h10C);

        // Branch arriving while 0x10 is still waiting.
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h400);
        check("br_wait_addr",     ibus_addr_o,         32'h10);
        check("br_wait_stallreq", {31'b0, stallreq_o}, 32'h1);
        drive(1'b1, 32'h110, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("br_slot_pc",   if_pc,   32'h10);
        check("br_slot_inst", if_inst, 32'h110);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("br_target_addr", ibus_addr_o,         32'h400);
        check("br_target_pc",   if_pc,               32'h400);
        check("br_target_req",  {31'b0, ibus_req_o}, 32'h1);
        drive(1'b1, 32'h500, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("br_target_inst", if_inst, 32'h500);

        // Flush while 0x404 is outstanding, with a branch left pending.
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h800);
        check("fl_pre_addr", ibus_addr_o, 32'h404);
        drive(1'b0, 32'h0, 6'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        check("fl_stallreq", {31'b0, stallreq_o}, 32'h1);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("disc_req",      {31'b0, ibus_req_o}, 32'h1);
        check("disc_addr",     ibus_addr_o,         32'h404);
        check("disc_pc",       if_pc,               32'h20);
        check("disc_stallreq", {31'b0, stallreq_o}, 32'h1);
        drive(1'b1, 32'hDEAD, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("disc_ack_inst",     if_inst,             32'h0);
        check("disc_ack_stallreq", {31'b0, stallreq_o}, 32'h1);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("disc_idle_req", {31'b0, ibus_req_o}, 32'h0);
        drive(1'b1, 32'h120, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("fl_new_addr", ibus_addr_o, 32'h20);
        check("fl_new_inst", if_inst,     32'h120);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("fl_pending_cleared_addr", ibus_addr_o, 32'h24);

        // Reset while 0x24 is outstanding; the late ack must be ignored.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'hBAD, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        check("mrst_req",      {31'b0, ibus_req_o}, 32'h0);
        check("mrst_addr",     ibus_addr_o,         32'h0);
        check("mrst_stallreq", {31'b0, stallreq_o}, 32'h1);
        check("mrst_inst",     if_inst,             32'h0);
        check("mrst_pc",       if_pc,               32'h0);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("restart_req",  {31'b0, ibus_req_o}, 32'h1);
        check("restart_addr", ibus_addr_o,         32'h0);
        check("restart_pc",   if_pc,               32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
